// File: rtl/rdma_sq_credit_gate.sv
// rdma_sq_credit_gate
// Credit-based flow control in front of the RDMA send-queue FIFO. Every accepted
// SQ command reserves one credit and every ack returned from the ack FIFO
// releases one, so at most MAX_OUTSTANDING operations are in flight. A
// drain_req/drained handshake lets software quiesce the path before
// reconfiguring the QP.
module rdma_sq_credit_gate #(
  parameter int MAX_OUTSTANDING = 16,
  parameter int SQ_W            = 256,
  parameter int ACK_W           = 32,
  parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic             aclk,
  input  logic             areset,
  // user SQ command in
  input  logic             s_sq_valid,
  output logic             s_sq_ready,
  input  logic [SQ_W-1:0]  s_sq_data,
  // SQ command toward send-queue FIFO
  output logic             m_sq_valid,
  input  logic             m_sq_ready,
  output logic [SQ_W-1:0]  m_sq_data,
  // ack from ack FIFO
  input  logic             s_ack_valid,
  output logic             s_ack_ready,
  input  logic [ACK_W-1:0] s_ack_data,
  // ack toward user
  output logic             m_ack_valid,
  input  logic             m_ack_ready,
  output logic [ACK_W-1:0] m_ack_data,
  // drain handshake and status
  input  logic             drain_req,
  output logic             drained,
  output logic [CNT_W-1:0] outstanding,
  output logic             credit_err
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_DRAIN,
    ST_IDLE
  } state_t;

  state_t            state_reg;
  logic              run_en_reg;      // low during reset and the first cycle after release
  logic              sq_full_reg;
  logic [SQ_W-1:0]   sq_data_reg;
  logic              ack_full_reg;
  logic [ACK_W-1:0]  ack_data_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic [CNT_W-1:0]  cnt_next;
  logic              credit_err_reg;
  logic              drained_reg;

  logic              credit_ok;
  logic              sq_accept;
  logic              ack_accept;
  logic              underflow;
  logic              sq_full_next;
  logic              quiet_next;

  // Ready generation: new commands only in RUN with a free credit, and never in
  // the cycle drain_req rises. The ack path ignores the FSM entirely.
  assign credit_ok   = (cnt_reg < MAX_CNT);
  assign s_sq_ready  = run_en_reg && (state_reg == ST_RUN) && !drain_req && credit_ok &&
                       (!sq_full_reg || m_sq_ready);
  assign s_ack_ready = run_en_reg && (!ack_full_reg || m_ack_ready);
  assign sq_accept   = s_sq_valid && s_sq_ready;
  assign ack_accept  = s_ack_valid && s_ack_ready;

  assign m_sq_valid  = sq_full_reg;
  assign m_sq_data   = sq_data_reg;
  assign m_ack_valid = ack_full_reg;
  assign m_ack_data  = ack_data_reg;
  assign outstanding = cnt_reg;
  assign credit_err  = credit_err_reg;
  assign drained     = drained_reg;

  // Next credit count: accept and ack in the same cycle cancel; an ack with
  // nothing outstanding leaves the count at zero and is flagged.
  always_comb begin
    cnt_next  = cnt_reg;
    underflow = 1'b0;
    if (sq_accept && !ack_accept) begin
      cnt_next = cnt_reg + 1'b1;
    end else if (ack_accept && !sq_accept) begin
      if (cnt_reg != '0) begin
        cnt_next = cnt_reg - 1'b1;
      end else begin
        underflow = 1'b1;
      end
    end
  end

  assign sq_full_next = sq_accept ? 1'b1 : (m_sq_ready ? 1'b0 : sq_full_reg);
  assign quiet_next   = (cnt_next == '0) && !sq_full_next;

  // Control state: slice occupancy, credit counter, error pulse, reset-release gate.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      run_en_reg     <= 1'b0;
      sq_full_reg    <= 1'b0;
      ack_full_reg   <= 1'b0;
      cnt_reg        <= '0;
      credit_err_reg <= 1'b0;
    end else begin
      run_en_reg     <= 1'b1;
      sq_full_reg    <= sq_full_next;
      if (ack_accept) begin
        ack_full_reg <= 1'b1;
      end else if (m_ack_ready) begin
        ack_full_reg <= 1'b0;
      end
      cnt_reg        <= cnt_next;
      credit_err_reg <= underflow;
    end
  end

  // Data registers load on handshake only; they need no reset.
  always_ff @(posedge aclk) begin
    if (sq_accept) begin
      sq_data_reg <= s_sq_data;
    end
    if (ack_accept) begin
      ack_data_reg <= s_ack_data;
    end
  end

  // Drain FSM with registered drained flag, computed from the post-edge state.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_reg   <= ST_RUN;
      drained_reg <= 1'b1;
    end else begin
      case (state_reg)
        ST_RUN: begin
          if (drain_req) begin
            state_reg   <= ST_DRAIN;
            drained_reg <= 1'b0;
          end else begin
            drained_reg <= quiet_next;
          end
        end
        ST_DRAIN: begin
          if (!drain_req) begin
            state_reg   <= ST_RUN;
            drained_reg <= quiet_next;
          end else if ((cnt_reg == '0) && !sq_full_reg) begin
            state_reg   <= ST_IDLE;
            drained_reg <= 1'b1;
          end else begin
            drained_reg <= 1'b0;
          end
        end
        ST_IDLE: begin
          if (!drain_req) begin
            state_reg   <= ST_RUN;
            drained_reg <= quiet_next;
          end else begin
            drained_reg <= 1'b1;
          end
        end
        default: begin
          state_reg   <= ST_RUN;
          drained_reg <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rdma_sq_credit_gate.sv
// tb_rdma_sq_credit_gate
// Directed checks of the credit gate with MAX_OUTSTANDING=4 and 32-bit commands.
module tb_rdma_sq_credit_gate;

  localparam int MAXO  = 4;
  localparam int SQ_W  = 32;
  localparam int ACK_W = 32;
  localparam int CNT_W = $clog2(MAXO + 1);

  logic             aclk;
  logic             areset;
  logic             s_sq_valid;
  logic             s_sq_ready;
  logic [SQ_W-1:0]  s_sq_data;
  logic             m_sq_valid;
  logic             m_sq_ready;
  logic [SQ_W-1:0]  m_sq_data;
  logic             s_ack_valid;
  logic             s_ack_ready;
  logic [ACK_W-1:0] s_ack_data;
  logic             m_ack_valid;
  logic             m_ack_ready;
  logic [ACK_W-1:0] m_ack_data;
  logic             drain_req;
  logic             drained;
  logic [CNT_W-1:0] outstanding;
  logic             credit_err;

  int checks_total;
  int checks_passed;

  rdma_sq_credit_gate #(
    .MAX_OUTSTANDING(MAXO),
    .SQ_W(SQ_W),
    .ACK_W(ACK_W)
  ) dut (
    .aclk(aclk),
    .areset(areset),
    .s_sq_valid(s_sq_valid),
    .s_sq_ready(s_sq_ready),
    .s_sq_data(s_sq_data),
    .m_sq_valid(m_sq_valid),
    .m_sq_ready(m_sq_ready),
    .m_sq_data(m_sq_data),
    .s_ack_valid(s_ack_valid),
    .s_ack_ready(s_ack_ready),
    .s_ack_data(s_ack_data),
    .m_ack_valid(m_ack_valid),
    .m_ack_ready(m_ack_ready),
    .m_ack_data(m_ack_data),
    .drain_req(drain_req),
    .drained(drained),
    .outstanding(outstanding),
    .credit_err(credit_err)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks_total++;
    if (got !== exp) begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      checks_passed++;
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  // Offer one command and hold it until accepted (bounded).
  task automatic send_cmd(input logic [SQ_W-1:0] d);
    int n;
    s_sq_valid = 1'b1;
    s_sq_data  = d;
    #1;
    n = 0;
    while (!s_sq_ready && n < 50) begin
      tick();
      n++;
    end
    if (!s_sq_ready) chk("sq_timeout", 64'd0, 64'd1);
    tick();
    s_sq_valid = 1'b0;
  endtask

  // Offer one ack and hold it until accepted (bounded).
  task automatic send_ack(input logic [ACK_W-1:0] d);
    int n;
    s_ack_valid = 1'b1;
    s_ack_data  = d;
    #1;
    n = 0;
    while (!s_ack_ready && n < 50) begin
      tick();
      n++;
    end
    if (!s_ack_ready) chk("ack_timeout", 64'd0, 64'd1);
    tick();
    s_ack_valid = 1'b0;
  endtask

  logic [SQ_W-1:0] cmd [100];
  logic [SQ_W-1:0] exp_q [$];
  logic [SQ_W-1:0] prev_data;
  logic            prev_stall;
  int idx, n, sent, owed, got, hold;
  bit hold_done;

  initial begin
    checks_total  = 0;
    checks_passed = 0;
    areset      = 1'b1;
    s_sq_valid  = 1'b0;
    s_sq_data   = '0;
    s_ack_valid = 1'b0;
    s_ack_data  = '0;
    m_sq_ready  = 1'b1;
    m_ack_ready = 1'b1;
    drain_req   = 1'b0;
    repeat (2) @(posedge aclk);
    #1;
    chk("rst_m_sq_valid", 64'(m_sq_valid), 64'd0);
    chk("rst_m_ack_valid", 64'(m_ack_valid), 64'd0);
    chk("rst_s_sq_ready", 64'(s_sq_ready), 64'd0);
    chk("rst_s_ack_ready", 64'(s_ack_ready), 64'd0);
    chk("rst_outstanding", 64'(outstanding), 64'd0);
    chk("rst_credit_err", 64'(credit_err), 64'd0);
    chk("rst_drained", 64'(drained), 64'd1);
    areset = 1'b0;
    tick();
    chk("post_rst_s_sq_ready", 64'(s_sq_ready), 64'd1);

    // 1: reset in the middle of a stream, observed with no clock edge
    send_cmd(32'h0000_0101);
    send_cmd(32'h0000_0102);
    send_cmd(32'h0000_0103);
    chk("t1_outstanding", 64'(outstanding), 64'd3);
    chk("t1_m_sq_valid", 64'(m_sq_valid), 64'd1);
    chk("t1_drained", 64'(drained), 64'd0);
    #1 areset = 1'b1;
    #1;
    chk("t1_async_outstanding", 64'(outstanding), 64'd0);
    chk("t1_async_m_sq_valid", 64'(m_sq_valid), 64'd0);
    chk("t1_async_s_sq_ready", 64'(s_sq_ready), 64'd0);
    chk("t1_async_s_ack_ready", 64'(s_ack_ready), 64'd0);
    chk("t1_async_drained", 64'(drained), 64'd1);
    #1 areset = 1'b0;
    tick();
    tick();
    chk("t1_rel_outstanding", 64'(outstanding), 64'd0);
    chk("t1_rel_drained", 64'(drained), 64'd1);
    chk("t1_rel_s_sq_ready", 64'(s_sq_ready), 64'd1);

    // 2: credit limit with 6 back-to-back offers
    idx = 0;
    for (int i = 0; i < 6; i++) begin
      s_sq_valid = 1'b1;
      s_sq_data  = 32'hA000_0000 + 32'(idx);
      #1;
      if (s_sq_ready) idx++;
      tick();
    end
    chk("t2_accepted", 64'(idx), 64'd4);
    chk("t2_s_sq_ready", 64'(s_sq_ready), 64'd0);
    chk("t2_outstanding", 64'(outstanding), 64'd4);
    s_ack_valid = 1'b1;
    s_ack_data  = 32'h1111_0001;
    #1;
    chk("t2_ack_ready", 64'(s_ack_ready), 64'd1);
    tick();
    s_ack_valid = 1'b0;
    chk("t2_after_ack_outstanding", 64'(outstanding), 64'd3);
    #1;
    chk("t2_fifth_ready", 64'(s_sq_ready), 64'd1);
    tick();
    s_sq_valid = 1'b0;
    chk("t2_fifth_outstanding", 64'(outstanding), 64'd4);
    chk("t2_fifth_data", 64'(m_sq_data), 64'hA000_0004);
    for (int i = 0; i < 4; i++) send_ack(32'h2222_0000 + 32'(i));
    tick();
    chk("t2_clean_outstanding", 64'(outstanding), 64'd0);

    // 3: SQ accept and ack handshake in the same cycle
    send_cmd(32'h0000_0301);
    send_cmd(32'h0000_0302);
    chk("t3_pre_outstanding", 64'(outstanding), 64'd2);
    s_sq_valid  = 1'b1;
    s_sq_data   = 32'hCAFE_0303;
    s_ack_valid = 1'b1;
    s_ack_data  = 32'hBEEF_0303;
    #1;
    chk("t3_both_ready", 64'({s_sq_ready, s_ack_ready}), 64'd3);
    tick();
    s_sq_valid  = 1'b0;
    s_ack_valid = 1'b0;
    chk("t3_outstanding", 64'(outstanding), 64'd2);
    chk("t3_m_sq_data", 64'(m_sq_data), 64'hCAFE_0303);
    chk("t3_m_sq_valid", 64'(m_sq_valid), 64'd1);
    chk("t3_m_ack_data", 64'(m_ack_data), 64'hBEEF_0303);
    chk("t3_m_ack_valid", 64'(m_ack_valid), 64'd1);
    chk("t3_credit_err", 64'(credit_err), 64'd0);
    send_ack(32'h3333_0001);
    send_ack(32'h3333_0002);
    tick();
    chk("t3_clean_outstanding", 64'(outstanding), 64'd0);

    // 5: ack with nothing outstanding
    s_ack_valid = 1'b1;
    s_ack_data  = 32'hDEAD_BEEF;
    tick();
    s_ack_valid = 1'b0;
    chk("t5_credit_err", 64'(credit_err), 64'd1);
    chk("t5_outstanding", 64'(outstanding), 64'd0);
    chk("t5_m_ack_data", 64'(m_ack_data), 64'hDEAD_BEEF);
    chk("t5_m_ack_valid", 64'(m_ack_valid), 64'd1);
    tick();
    chk("t5_credit_err_drop", 64'(credit_err), 64'd0);

    // 4: random backpressure with a forced 10-cycle stall, 100 commands
    for (int i = 0; i < 100; i++) cmd[i] = $urandom;
    sent = 0; owed = 0; got = 0; hold = 0; hold_done = 0; n = 0;
    prev_stall = 1'b0; prev_data = '0;
    while (!(sent == 100 && exp_q.size() == 0 && owed == 0) && n < 3000) begin
      if (!hold_done && sent >= 30 && m_sq_valid) begin
        hold = 10;
        hold_done = 1;
      end
      s_sq_valid  = (sent < 100);
      s_sq_data   = cmd[(sent < 100) ? sent : 99];
      m_sq_ready  = (hold > 0) ? 1'b0 : 1'($urandom_range(0, 1));
      s_ack_valid = (owed > 0);
      s_ack_data  = 32'(n);
      #1;
      if (prev_stall) begin
        chk("t4_hold_valid", 64'(m_sq_valid), 64'd1);
        chk("t4_hold_data", 64'(m_sq_data), 64'(prev_data));
      end
      if (hold > 0) begin
        chk("t4_stall_s_sq_ready", 64'(s_sq_ready), 64'd0);
        hold--;
      end
      if (m_sq_valid && m_sq_ready) begin
        if (exp_q.size() > 0) chk("t4_data", 64'(m_sq_data), 64'(exp_q.pop_front()));
        else chk("t4_duplicate", 64'd1, 64'd0);
        got++;
        owed++;
      end
      if (s_sq_valid && s_sq_ready) begin
        exp_q.push_back(s_sq_data);
        sent++;
      end
      if (s_ack_valid && s_ack_ready) owed--;
      prev_stall = m_sq_valid && !m_sq_ready;
      prev_data  = m_sq_data;
      tick();
      n++;
    end
    s_sq_valid  = 1'b0;
    s_ack_valid = 1'b0;
    m_sq_ready  = 1'b1;
    chk("t4_in_time", 64'(n < 3000), 64'd1);
    chk("t4_received", 64'(got), 64'd100);
    chk("t4_hold_seen", 64'(hold_done), 64'd1);
    tick();
    tick();
    chk("t4_outstanding", 64'(outstanding), 64'd0);

    // 6: drain handshake
    send_cmd(32'h0000_0601);
    send_cmd(32'h0000_0602);
    send_cmd(32'h0000_0603);
    tick();
    chk("t6_outstanding", 64'(outstanding), 64'd3);
    s_sq_valid = 1'b1;
    s_sq_data  = 32'h0000_0604;
    drain_req  = 1'b1;
    #1;
    chk("t6_ready_drop", 64'(s_sq_ready), 64'd0);
    tick();
    s_sq_valid = 1'b0;
    chk("t6_draining", 64'(drained), 64'd0);
    send_ack(32'h6666_0001);
    send_ack(32'h6666_0002);
    send_ack(32'h6666_0003);
    n = 0;
    while (!drained && n < 20) begin
      tick();
      n++;
    end
    chk("t6_drained", 64'(drained), 64'd1);
    chk("t6_idle_outstanding", 64'(outstanding), 64'd0);
    chk("t6_idle_s_sq_ready", 64'(s_sq_ready), 64'd0);
    tick();
    chk("t6_idle_stays", 64'(drained), 64'd1);
    drain_req = 1'b0;
    tick();
    chk("t6_run_ready", 64'(s_sq_ready), 64'd1);
    chk("t6_run_drained", 64'(drained), 64'd1);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
